// File: rtl/ks_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ks_adder_pipe
// Brief    : Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake
//            and a global stall when the output is backpressured.
// Revision : 1.0  initial release
// ============================================================================
module ks_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int SUB_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int MSB    = WIDTH - 1;

    // Stage 0 holds the operand-derived terms; stage s holds the result of prefix level s.
    logic             r_v    [0:LEVELS];
    logic [WIDTH-1:0] r_g    [0:LEVELS];
    logic [WIDTH-1:0] r_pp   [0:LEVELS];
    logic [WIDTH-1:0] r_p    [0:LEVELS];
    logic             r_c0   [0:LEVELS];
    logic             r_amsb [0:LEVELS];
    logic             r_bmsb [0:LEVELS];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_sub_eff;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic             w_adv;

    logic [WIDTH-1:0] w_g_nxt  [1:LEVELS];
    logic [WIDTH-1:0] w_pp_nxt [1:LEVELS];

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    assign w_sub_eff = (SUB_EN != 0) ? sub : 1'b0;
    assign w_bp      = w_sub_eff ? ~b : b;
    assign w_c0      = w_sub_eff | cin;

    // Whole pipeline moves together; it only freezes when the output slot is occupied and blocked.
    assign w_adv     = ~r_out_valid | out_ready;
    assign in_ready  = w_adv;

    // Kogge-Stone level s combines each bit with the group 2^(s-1) positions below it.
    always_comb begin
        for (int s = 1; s <= LEVELS; s++) begin
            w_g_nxt[s]  = r_g[s-1];
            w_pp_nxt[s] = r_pp[s-1];
            for (int i = (1 << (s-1)); i < WIDTH; i++) begin
                w_g_nxt[s][i]  = r_g[s-1][i] | (r_pp[s-1][i] & r_g[s-1][i - (1 << (s-1))]);
                w_pp_nxt[s][i] = r_pp[s-1][i] & r_pp[s-1][i - (1 << (s-1))];
            end
        end
    end

    // Carry-in enters only here: carry into bit i is G[i-1:0] | P[i-1:0] & c0.
    always_comb begin
        w_carry    = '0;
        w_carry[0] = r_c0[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
            w_carry[i] = r_g[LEVELS][i-1] | (r_pp[LEVELS][i-1] & r_c0[LEVELS]);
        end
    end

    assign w_sum  = r_p[LEVELS] ^ w_carry;
    assign w_cout = r_g[LEVELS][MSB] | (r_pp[LEVELS][MSB] & r_c0[LEVELS]);
    assign w_ovf  = (r_amsb[LEVELS] == r_bmsb[LEVELS]) & (w_sum[MSB] != r_amsb[LEVELS]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LEVELS; s++) begin
                r_v[s] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            for (int s = 1; s <= LEVELS; s++) begin
                r_v[s] <= r_v[s-1];
            end
            r_out_valid <= r_v[LEVELS];
            if (r_v[LEVELS]) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    // Datapath carries no reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_g[0]    <= a & w_bp;
            r_pp[0]   <= a ^ w_bp;
            r_p[0]    <= a ^ w_bp;
            r_c0[0]   <= w_c0;
            r_amsb[0] <= a[MSB];
            r_bmsb[0] <= w_bp[MSB];
            for (int s = 1; s <= LEVELS; s++) begin
                r_g[s]    <= w_g_nxt[s];
                r_pp[s]   <= w_pp_nxt[s];
                r_p[s]    <= r_p[s-1];
                r_c0[s]   <= r_c0[s-1];
                r_amsb[s] <= r_amsb[s-1];
                r_bmsb[s] <= r_bmsb[s-1];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
